load_store_unit: RTL and testbench

Memory-access initiator between the datapath and `data_memory`. Accepts one load or store request at a time over a valid/ready handshake and drives `data_memory`'s `MemRead`/`MemWrite` port set. Splits misaligned word accesses into two byte accesses and merges them back. Returns load data zero- or sign-extended, with a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 8 +
 rtl/lsu_align.sv | 29 ++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;
  localparam int unsigned ADDR_W = 16;
  localparam logic MEM_WORD = 1'b0;
  localparam logic MEM_BYTE = 1'b1;

  typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP} lsuState_e;
endpackage

// File: rtl/lsu_align.sv
// Split decision, per-phase address/data/size and load byte merge/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  input  logic              isByte,
  input  logic              isSigned,
  input  logic              phase1,
  input  logic [7:0]        loByte,
  input  logic [15:0]       readData,
  output logic              split,
  output logic [ADDR_W-1:0] phAddr,
  output logic [15:0]       phWData,
  output logic              phSize,
  output logic [15:0]       loadResult
);
  always_comb begin
    split   = !isByte & addr[0];
    phAddr  = phase1 ? addr + 1'b1 : addr;
    phSize  = (phase1 | isByte | split) ? MEM_BYTE : MEM_WORD;
    phWData = wdata;
    if (split) phWData = phase1 ? {8'h00, wdata[15:8]} : {8'h00, wdata[7:0]};

    if (isByte)     loadResult = {{8{isSigned & readData[7]}}, readData[7:0]};
    else if (split) loadResult = {readData[7:0], loByte};
    else            loadResult = readData;
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator driving data_memory's port set.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic              req_d,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] ReadAddr,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [15:0]       writeData,
  input  logic [15:0]       readData,
  output logic              MemSize,
  output logic              MemD
);
  localparam bit HAS_WAIT = (RD_LAT != 0);
  localparam logic [1:0] WAIT_INIT = HAS_WAIT ? 2'(RD_LAT - 1) : 2'd0;

  lsuState_e state, nextState;
  logic              latWe, latByte, latSigned, latD;
  logic [ADDR_W-1:0] latAddr;
  logic [15:0]       latWData;
  logic [7:0]        loByte;
  logic [1:0]        waitCnt;

  logic              accept, selWe, selByte, selSigned, selD;
  logic [ADDR_W-1:0] selAddr;
  logic [15:0]       selWData;
  logic              phase1Next, activeNext, accNext, inAcc, inWait, capture;
  logic              split, phSize;
  logic [ADDR_W-1:0] phAddr;
  logic [15:0]       phWData, loadResult;

  // Memory outputs are registered from the next state, so on the accept edge
  // the phase-0 values must come straight from the request inputs.
  always_comb begin
    accept    = (state == IDLE) & req_valid;
    selWe     = accept ? req_we     : latWe;
    selByte   = accept ? req_byte   : latByte;
    selSigned = accept ? req_signed : latSigned;
    selD      = accept ? req_d      : latD;
    selAddr   = accept ? req_addr   : latAddr;
    selWData  = accept ? req_wdata  : latWData;
  end

  lsu_align uAlign (
    .addr      (selAddr),
    .wdata     (selWData),
    .isByte    (selByte),
    .isSigned  (selSigned),
    .phase1    (phase1Next),
    .loByte    (loByte),
    .readData  (readData),
    .split     (split),
    .phAddr    (phAddr),
    .phWData   (phWData),
    .phSize    (phSize),
    .loadResult(loadResult)
  );

  always_comb begin
    nextState = state;
    inAcc     = (state == ACC0) | (state == ACC1);
    inWait    = (state == WAIT0) | (state == WAIT1);
    unique case (state)
      IDLE:  if (req_valid) nextState = ACC0;
      ACC0:  if (!latWe && HAS_WAIT) nextState = WAIT0;
             else                    nextState = split ? ACC1 : RESP;
      WAIT0: if (waitCnt == 2'd0)    nextState = split ? ACC1 : RESP;
      ACC1:  nextState = (!latWe && HAS_WAIT) ? WAIT1 : RESP;
      WAIT1: if (waitCnt == 2'd0)    nextState = RESP;
      RESP:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
    phase1Next = (nextState == ACC1) | (nextState == WAIT1);
    accNext    = (nextState == ACC0) | (nextState == ACC1);
    activeNext = accNext | (nextState == WAIT0) | (nextState == WAIT1);
    capture    = !latWe & ((inAcc & !HAS_WAIT) | (inWait & (waitCnt == 2'd0)));
    req_ready  = (state == IDLE);
    rsp_valid  = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      latWe     <= 1'b0;
      latByte   <= 1'b0;
      latSigned <= 1'b0;
      latD      <= 1'b0;
      latAddr   <= '0;
      latWData  <= '0;
      loByte    <= '0;
      waitCnt   <= '0;
      rsp_rdata <= '0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      ReadAddr  <= '0;
      WriteAddr <= '0;
      writeData <= '0;
      MemSize   <= 1'b0;
      MemD      <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        latWe     <= req_we;
        latByte   <= req_byte;
        latSigned <= req_signed;
        latD      <= req_d;
        latAddr   <= req_addr;
        latWData  <= req_wdata;
      end
      if (inAcc && (nextState == WAIT0 || nextState == WAIT1)) waitCnt <= WAIT_INIT;
      else if (inWait && waitCnt != 2'd0)                      waitCnt <= waitCnt - 2'd1;
      if (capture) begin
        if (nextState == RESP) rsp_rdata <= loadResult;
        else                   loByte    <= readData[7:0];
      end
      MemRead   <= activeNext & !selWe;
      MemWrite  <= accNext & selWe;
      ReadAddr  <= (activeNext & !selWe) ? phAddr : '0;
      WriteAddr <= (accNext & selWe) ? phAddr : '0;
      writeData <= (accNext & selWe) ? phWData : '0;
      MemSize   <= activeNext ? phSize : MEM_WORD;
      MemD      <= activeNext & selD;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory plus a request-level reference model.
module tb_load_store_unit;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_byte = 1'b0, req_signed = 1'b0, req_d = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, MemRead, MemWrite, MemSize, MemD;
  logic [15:0] rsp_rdata, ReadAddr, WriteAddr, writeData;
  logic [15:0] readData = '0;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte(req_byte), .req_signed(req_signed),
    .req_d(req_d), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .MemRead(MemRead),
    .MemWrite(MemWrite), .ReadAddr(ReadAddr), .WriteAddr(WriteAddr), .writeData(writeData),
    .readData(readData), .MemSize(MemSize), .MemD(MemD)
  );

  // Memory environment: little-endian byte array, registered read (RD_LAT = 1).
  logic [7:0] mem    [0:65535];
  logic [7:0] refMem [0:65535];

  always @(posedge clk) begin
    if (MemWrite) begin
      mem[WriteAddr] = writeData[7:0];
      if (!MemSize) mem[WriteAddr + 16'd1] = writeData[15:8];
    end
    if (MemRead)
      readData <= MemSize ? {8'($urandom), mem[ReadAddr]} : {mem[ReadAddr + 16'd1], mem[ReadAddr]};
  end

  typedef struct packed {logic [15:0] a; logic [15:0] d; logic sz; logic md;} memEv_t;
  memEv_t wrQ[$], rdQ[$];
  logic        prevRd = 1'b0;
  logic [15:0] prevRa = '0;
  int          bothHigh = 0;

  always @(negedge clk) begin
    if (MemRead && MemWrite) bothHigh++;
    if (MemWrite) wrQ.push_back('{WriteAddr, writeData, MemSize, MemD});
    if (MemRead && !(prevRd && ReadAddr == prevRa)) rdQ.push_back('{ReadAddr, 16'h0000, MemSize, MemD});
    prevRd = MemRead;
    prevRa = ReadAddr;
  end

  function automatic int expLat(logic we, logic [15:0] a, logic isByte);
    logic sp;
    sp = !isByte && a[0];
    if (we) return sp ? 3 : 2;
    return sp ? 2 * RD_LAT + 3 : RD_LAT + 2;
  endfunction

  function automatic logic [15:0] expLoad(logic [15:0] a, logic isByte, logic isSigned);
    logic [7:0]  v;
    logic [15:0] a1;
    a1 = a + 16'd1;
    v  = refMem[a];
    if (isByte) return isSigned ? {{8{v[7]}}, v} : {8'h00, v};
    return {refMem[a1], refMem[a]};
  endfunction

  function automatic void refStore(logic [15:0] a, logic [15:0] wd, logic isByte);
    logic [15:0] a1;
    a1 = a + 16'd1;
    refMem[a] = wd[7:0];
    if (!isByte) refMem[a1] = wd[15:8];
  endfunction

  task automatic runTxn(input logic we, input logic [15:0] a, input logic [15:0] wd, input logic isByte,
                        input logic isSigned, input logic d, output int lat, output logic [15:0] rd);
    int guard;
    @(negedge clk);
    wrQ.delete();
    rdQ.delete();
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    req_byte = isByte; req_signed = isSigned; req_d = d;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    req_byte = 1'($urandom); req_signed = 1'($urandom); req_d = 1'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 40);
    rd = rsp_rdata;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", rsp_rdata); end
    checks++; if ({MemRead, MemWrite, MemSize, MemD} !== 4'b0000)
      begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {MemRead, MemWrite, MemSize, MemD}); end
    checks++; if ({ReadAddr, WriteAddr, writeData} !== 48'h0)
      begin errors++; $display("FAIL reset_buses got=%h exp=0", {ReadAddr, WriteAddr, writeData}); end
  endtask

  task automatic test_aligned;
    int lat;
    logic [15:0] rd;
    runTxn(1'b1, 16'h0010, 16'hABCD, 1'b0, 1'b0, 1'b0, lat, rd);
    refStore(16'h0010, 16'hABCD, 1'b0);
    checks++; if (lat !== expLat(1'b1, 16'h0010, 1'b0)) begin errors++; $display("FAIL aligned_store_lat got=%0d exp=%0d", lat, expLat(1'b1, 16'h0010, 1'b0)); end
    checks++; if (wrQ.size() != 1 || wrQ[0] !== memEv_t'{16'h0010, 16'hABCD, 1'b0, 1'b0})
      begin errors++; $display("FAIL aligned_store_write got=%0d writes first=%h exp=1 write 0010/abcd size0", wrQ.size(), wrQ.size() ? wrQ[0] : '0); end
    runTxn(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, lat, rd);
    checks++; if (lat !== RD_LAT + 2) begin errors++; $display("FAIL aligned_load_lat got=%0d exp=%0d", lat, RD_LAT + 2); end
    checks++; if (rd !== expLoad(16'h0010, 1'b0, 1'b0)) begin errors++; $display("FAIL aligned_load_data got=%h exp=%h", rd, expLoad(16'h0010, 1'b0, 1'b0)); end
    checks++; if (rdQ.size() != 1 || rdQ[0].a !== 16'h0010 || rdQ[0].sz !== 1'b0)
      begin errors++; $display("FAIL aligned_load_read got=%0d reads exp=1 word read at 0010", rdQ.size()); end
  endtask

  task automatic test_split;
    int lat;
    logic [15:0] rd;
    runTxn(1'b1, 16'h0021, 16'hCFCF, 1'b0, 1'b0, 1'b1, lat, rd);
    refStore(16'h0021, 16'hCFCF, 1'b0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL split_store_lat got=%0d exp=3", lat); end
    checks++; if (wrQ.size() != 2 || wrQ[0] !== memEv_t'{16'h0021, 16'h00CF, 1'b1, 1'b1} || wrQ[1] !== memEv_t'{16'h0022, 16'h00CF, 1'b1, 1'b1})
      begin errors++; $display("FAIL split_store_writes got=%0d writes exp=2 byte writes 0021,0022 <- cf", wrQ.size()); end
    runTxn(1'b0, 16'h0021, 16'h0000, 1'b0, 1'b0, 1'b0, lat, rd);
    checks++; if (lat !== 2 * RD_LAT + 3) begin errors++; $display("FAIL split_load_lat got=%0d exp=%0d", lat, 2 * RD_LAT + 3); end
    checks++; if (rd !== expLoad(16'h0021, 1'b0, 1'b0)) begin errors++; $display("FAIL split_load_data got=%h exp=%h", rd, expLoad(16'h0021, 1'b0, 1'b0)); end
    checks++; if (rdQ.size() != 2 || rdQ[0].a !== 16'h0021 || rdQ[1].a !== 16'h0022 || rdQ[0].sz !== 1'b1 || rdQ[1].sz !== 1'b1)
      begin errors++; $display("FAIL split_load_reads got=%0d reads exp=2 byte reads 0021,0022", rdQ.size()); end
  endtask

  task automatic test_byte_ext;
    int lat;
    logic [15:0] rd;
    runTxn(1'b1, 16'h0040, 16'h7785, 1'b1, 1'b0, 1'b0, lat, rd);
    refStore(16'h0040, 16'h7785, 1'b1);
    checks++; if (wrQ.size() != 1 || wrQ[0].a !== 16'h0040 || wrQ[0].d[7:0] !== 8'h85 || wrQ[0].sz !== 1'b1)
      begin errors++; $display("FAIL byte_store_write got=%0d writes exp=1 byte write 0040 <- 85", wrQ.size()); end
    for (int s = 0; s < 2; s++) begin
      runTxn(1'b0, 16'h0040, 16'h0000, 1'b1, 1'(1 - s), 1'(1 - s), lat, rd);
      checks++; if (rd !== expLoad(16'h0040, 1'b1, 1'(1 - s)))
        begin errors++; $display("FAIL byte_load_ext signed=%0d got=%h exp=%h", 1 - s, rd, expLoad(16'h0040, 1'b1, 1'(1 - s))); end
      checks++; if (lat !== RD_LAT + 2) begin errors++; $display("FAIL byte_load_lat got=%0d exp=%0d", lat, RD_LAT + 2); end
      checks++; if (rdQ.size() != 1 || rdQ[0].sz !== 1'b1 || rdQ[0].md !== 1'(1 - s))
        begin errors++; $display("FAIL byte_load_size_d got=%0d reads exp=1 read size1 d=%0d", rdQ.size(), 1 - s); end
    end
  endtask

  task automatic test_wrap;
    int lat;
    logic [15:0] rd;
    runTxn(1'b1, 16'hFFFF, 16'h0034, 1'b1, 1'b0, 1'b0, lat, rd);
    refStore(16'hFFFF, 16'h0034, 1'b1);
    runTxn(1'b1, 16'h0000, 16'h0012, 1'b1, 1'b0, 1'b0, lat, rd);
    refStore(16'h0000, 16'h0012, 1'b1);
    runTxn(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, lat, rd);
    checks++; if (rd !== expLoad(16'hFFFF, 1'b0, 1'b0)) begin errors++; $display("FAIL wrap_load_data got=%h exp=%h", rd, expLoad(16'hFFFF, 1'b0, 1'b0)); end
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL wrap_load_const got=%h exp=1234", rd); end
    checks++; if (rdQ.size() != 2 || rdQ[0].a !== 16'hFFFF || rdQ[1].a !== 16'h0000)
      begin errors++; $display("FAIL wrap_read_addrs got=%0d reads exp=ffff then 0000", rdQ.size()); end
  endtask

  task automatic test_reset_mid;
    int seen, lat, guard;
    logic [15:0] rd;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_byte = 1'b0; req_signed = 1'b0; req_d = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    checks++; if (MemRead !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_pre_state got=%b%b exp=10 (MemRead,req_ready)", MemRead, req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (MemRead !== 1'b0) begin errors++; $display("FAIL mid_memread got=%b exp=0", MemRead); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", req_ready); end
    checks++; if ({ReadAddr, MemSize, MemD, rsp_valid, rsp_rdata} !== 35'h0)
      begin errors++; $display("FAIL mid_outputs got=%h exp=0", {ReadAddr, MemSize, MemD, rsp_valid, rsp_rdata}); end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_rsp got=%0d exp=0", seen); end
    runTxn(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, lat, rd);
    checks++; if (rd !== expLoad(16'h0010, 1'b0, 1'b0) || lat !== RD_LAT + 2)
      begin errors++; $display("FAIL mid_recover got=%h/%0d exp=%h/%0d", rd, lat, expLoad(16'h0010, 1'b0, 1'b0), RD_LAT + 2); end
  endtask

  task automatic test_back_to_back;
    localparam int N = 16;
    int accepts, rsps, outstanding, cyc, bothStart;
    logic [15:0] expQ[$];
    logic        ldQ[$];
    logic [15:0] expd, lastRd;
    logic        ld, haveRd, took;
    accepts = 0; rsps = 0; outstanding = 0; cyc = 0; haveRd = 1'b0; lastRd = '0;
    bothStart = bothHigh;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0100 + 16'($urandom_range(0, 15));
    req_wdata = 16'($urandom); req_byte = 1'($urandom); req_signed = 1'($urandom); req_d = 1'($urandom);
    while ((accepts < N || rsps < N) && cyc < 600) begin
      if (rsp_valid) begin
        rsps++; outstanding--;
        ld = ldQ.pop_front(); expd = expQ.pop_front();
        if (ld) begin haveRd = 1'b1; lastRd = expd; end
        if (ld || haveRd) begin
          checks++; if (rsp_rdata !== lastRd) begin errors++; $display("FAIL b2b_rdata rsp=%0d load=%b got=%h exp=%h", rsps, ld, rsp_rdata, lastRd); end
        end
      end
      took = req_valid && req_ready;
      if (took) begin
        checks++; if (outstanding != 0) begin errors++; $display("FAIL b2b_single_accept got=%0d outstanding exp=0", outstanding); end
        accepts++; outstanding++;
        ldQ.push_back(!req_we);
        if (req_we) begin refStore(req_addr, req_wdata, req_byte); expQ.push_back('0); end
        else expQ.push_back(expLoad(req_addr, req_byte, req_signed));
      end
      @(posedge clk); #1;
      if (took) begin
        if (accepts < N) begin
          req_we = 1'(accepts % 2 == 0); req_addr = 16'h0100 + 16'($urandom_range(0, 15));
          req_wdata = 16'($urandom); req_byte = 1'($urandom); req_signed = 1'($urandom); req_d = 1'($urandom);
        end else req_valid = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    req_valid = 1'b0;
    checks++; if (accepts != N) begin errors++; $display("FAIL b2b_accepts got=%0d exp=%0d", accepts, N); end
    checks++; if (rsps != accepts) begin errors++; $display("FAIL b2b_rsps got=%0d exp=%0d", rsps, accepts); end
    checks++; if (bothHigh != bothStart) begin errors++; $display("FAIL b2b_exclusive got=%0d overlaps exp=0", bothHigh - bothStart); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin mem[i] = 8'h00; refMem[i] = 8'h00; end
    test_reset();
    test_aligned();
    test_split();
    test_byte_ext();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
